// File: rtl/chacha_inv_rounds_if.sv
// Handshake bundle for the inverse-round block: input state stream in, recovered state stream out.
interface chacha_inv_rounds_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] state_out;
    logic         busy;

    modport master (
        output in_valid,
        output state_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  state_out,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  state_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output state_out,
        output busy
    );
endinterface

// File: rtl/chacha_inv_rounds.sv
// Undoes ROUNDS ChaCha half-rounds, one inverse QR step (x4 groups) per clock; result after 4*ROUNDS edges.
// Holds the result until out_ready; accepts a new state only in IDLE.
module chacha_inv_rounds #(
    parameter int ROUNDS = 20
) (
    input logic               clk,
    input logic               rst,
    chacha_inv_rounds_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [4:0] H_INIT = 5'(ROUNDS - 1);

    state_e            state_q, state_d;
    logic [15:0][31:0] work_q, work_d;
    logic [15:0][31:0] stepped;
    logic [4:0]        h_q, h_d;
    logic [1:0]        step_q, step_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic [3:0]  ia, ib, ic, id;
    logic [31:0] a, b, c, d;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Word index of role `row` (a..d) in group g: diagonals shift the column by row.
    function automatic logic [3:0] widx(input logic [1:0] row, input logic [1:0] g, input logic diag);
        logic [1:0] col;
        col = g + (diag ? row : 2'd0);
        return {row, col};
    endfunction

    always_comb begin
        stepped = work_q;
        ia = '0; ib = '0; ic = '0; id = '0;
        a  = '0; b  = '0; c  = '0; d  = '0;
        for (int g = 0; g < 4; g++) begin
            ia = widx(2'd0, g[1:0], h_q[0]);
            ib = widx(2'd1, g[1:0], h_q[0]);
            ic = widx(2'd2, g[1:0], h_q[0]);
            id = widx(2'd3, g[1:0], h_q[0]);
            a  = work_q[ia];
            b  = work_q[ib];
            c  = work_q[ic];
            d  = work_q[id];
            case (step_q)
                2'd3: begin
                    stepped[ib] = rotr(b, 7) ^ c;
                    stepped[ic] = c - d;
                end
                2'd2: begin
                    stepped[ia] = a - b;
                    stepped[id] = rotr(d, 8) ^ a;
                end
                2'd1: begin
                    stepped[ib] = rotr(b, 12) ^ c;
                    stepped[ic] = c - d;
                end
                default: begin
                    stepped[ia] = a - b;
                    stepped[id] = rotr(d, 16) ^ a;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        h_d     = h_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d  = bus.state_in;
                    h_d     = H_INIT;
                    step_d  = 2'd3;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d = stepped;
                if (step_q != 2'd0) begin
                    step_d = step_q - 2'd1;
                end else if (h_q == 5'd0) begin
                    state_d = DONE;
                end else begin
                    h_d    = h_q - 5'd1;
                    step_d = 2'd3;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            h_q         <= '0;
            step_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            h_q         <= h_d;
            step_q      <= step_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // The working register is only written in IDLE/RUN, so it is stable throughout DONE.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.state_out = work_q;

endmodule
